// File: rtl/insn_encoder.sv
// RV32I instruction packer: encodes decoded fields plus a 32-bit immediate into one
// instruction word per handshake, with range/alignment checks and a word-address counter.
module insn_encoder #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              i_valid,
   output logic              i_ready,
   input  logic [2:0]        i_fmt,
   input  logic [6:0]        i_opcode,
   input  logic [4:0]        i_rd,
   input  logic [4:0]        i_rs1,
   input  logic [4:0]        i_rs2,
   input  logic [2:0]        i_funct3,
   input  logic [6:0]        i_funct7,
   input  logic [31:0]       i_imm,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [31:0]       o_insn,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_err,
   output logic [1:0]        o_err_code,
   output logic              o_full
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] CAP = {1'b1, {ADDR_W{1'b0}}};

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_ALIGN = 2'd1;
   localparam logic [1:0] ERR_RANGE = 2'd2;
   localparam logic [1:0] ERR_FMT   = 2'd3;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HOLD  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       insn_q, insn_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              full_q, full_d;
   logic [1:0]        code_q, code_d;

   logic [31:0]       enc_c;
   logic [1:0]        chk_c;
   logic              fits12_c, fits13_c, fits21_c;
   logic              accept_c, legal_c, consume_c;

   // Field packing per format
   always_comb begin
      enc_c = '0;
      case (i_fmt)
         FMT_R: enc_c = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
         FMT_I: enc_c = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
         FMT_S: enc_c = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
         FMT_B: enc_c = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                         i_imm[4:1], i_imm[11], i_opcode};
         FMT_U: enc_c = {i_imm[31:12], i_rd, i_opcode};
         FMT_J: enc_c = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
         default: enc_c = '0;
      endcase
   end

   // A value fits an N-bit signed field when all bits above N-1 equal the sign bit
   assign fits12_c = (&i_imm[31:11]) | ~(|i_imm[31:11]);
   assign fits13_c = (&i_imm[31:12]) | ~(|i_imm[31:12]);
   assign fits21_c = (&i_imm[31:20]) | ~(|i_imm[31:20]);

   always_comb begin
      chk_c = ERR_NONE;
      if (i_fmt > FMT_J) begin
         chk_c = ERR_FMT;
      end else if (((i_fmt == FMT_B || i_fmt == FMT_J) && i_imm[0]) ||
                   (i_fmt == FMT_U && i_imm[11:0] != 12'd0)) begin
         chk_c = ERR_ALIGN;
      end else if (((i_fmt == FMT_I || i_fmt == FMT_S) && !fits12_c) ||
                   (i_fmt == FMT_B && !fits13_c) ||
                   (i_fmt == FMT_J && !fits21_c)) begin
         chk_c = ERR_RANGE;
      end
   end

   assign i_ready   = !stall && (state != FULL) && (state == EMPTY || o_ready);
   assign accept_c  = i_valid && i_ready;
   assign legal_c   = accept_c && (chk_c == ERR_NONE);
   assign consume_c = valid_q && o_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= EMPTY;
         addr_q  <= ADDR_W'(BASE_ADDR);
         count_q <= '0;
         insn_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         full_q  <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state   <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         insn_q  <= insn_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         full_q  <= full_d;
         code_q  <= code_d;
      end
   end

   // Capacity check on consume wins over a same-cycle new word
   always_comb begin
      state_d = state;
      addr_d  = addr_q;
      count_d = count_q;
      insn_d  = insn_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      full_d  = full_q;
      code_d  = code_q;

      if (accept_c && chk_c != ERR_NONE) begin
         err_d  = 1'b1;
         code_d = chk_c;
      end

      if (consume_c) begin
         addr_d  = addr_q + ADDR_W'(1);
         count_d = count_q + CNT_W'(1);
         if (count_d == CAP) begin
            state_d = FULL;
            valid_d = 1'b0;
            full_d  = 1'b1;
         end else if (legal_c) begin
            state_d = HOLD;
            valid_d = 1'b1;
            insn_d  = enc_c;
         end else begin
            state_d = EMPTY;
            valid_d = 1'b0;
         end
      end else if (legal_c) begin
         state_d = HOLD;
         valid_d = 1'b1;
         insn_d  = enc_c;
      end
   end

   assign o_valid    = valid_q;
   assign o_insn     = insn_q;
   assign o_addr     = addr_q;
   assign o_err      = err_q;
   assign o_err_code = code_q;
   assign o_full     = full_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Bench for insn_encoder: directed plan scenarios plus randomized traffic against a
// transaction-level model; a second instance with ADDR_W=2 exercises the capacity limit.
module tb_insn_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b, stall, i_valid, o_ready;
   logic [2:0]  i_fmt, i_funct3;
   logic [6:0]  i_opcode, i_funct7;
   logic [4:0]  i_rd, i_rs1, i_rs2;
   logic [31:0] i_imm;

   logic        a_i_ready, a_o_valid, a_o_err, a_o_full;
   logic [31:0] a_o_insn;
   logic [9:0]  a_o_addr;
   logic [1:0]  a_o_err_code;

   logic        b_i_ready, b_o_valid, b_o_err, b_o_full;
   logic [31:0] b_o_insn;
   logic [1:0]  b_o_addr;
   logic [1:0]  b_o_err_code;

   insn_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (
      .clk(clk), .rst(rst_a), .stall(stall), .i_valid(i_valid), .i_ready(a_i_ready),
      .i_fmt(i_fmt), .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
      .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
      .o_valid(a_o_valid), .o_ready(o_ready), .o_insn(a_o_insn), .o_addr(a_o_addr),
      .o_err(a_o_err), .o_err_code(a_o_err_code), .o_full(a_o_full));

   insn_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
      .clk(clk), .rst(rst_b), .stall(stall), .i_valid(i_valid), .i_ready(b_i_ready),
      .i_fmt(i_fmt), .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
      .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
      .o_valid(b_o_valid), .o_ready(o_ready), .o_insn(b_o_insn), .o_addr(b_o_addr),
      .o_err(b_o_err), .o_err_code(b_o_err_code), .o_full(b_o_full));

   int errors = 0;
   int checks = 0;

   // Transaction-level model of the active instance
   bit          sel = 1'b0;
   int          m_cap = 1024;
   bit          m_held, m_full, m_err;
   logic [31:0] m_insn;
   logic [1:0]  m_code;
   int          m_addr, m_count;

   function automatic void model_reset();
      m_held = 1'b0; m_full = 1'b0; m_err = 1'b0;
      m_insn = '0; m_code = 2'd0; m_addr = 0; m_count = 0;
   endfunction

   function automatic bit m_ready();
      return !stall && !m_full && (!m_held || o_ready);
   endfunction

   function automatic logic [1:0] ref_code(logic [2:0] fmt, logic [31:0] imm);
      int s;
      s = $signed(imm);
      if (fmt > 3'd5) return 2'd3;
      if ((fmt == 3'd3 || fmt == 3'd5) && imm[0]) return 2'd1;
      if (fmt == 3'd4 && (imm & 32'hfff) != 32'd0) return 2'd1;
      if ((fmt == 3'd1 || fmt == 3'd2) && (s < -2048 || s > 2047)) return 2'd2;
      if (fmt == 3'd3 && (s < -4096 || s > 4094)) return 2'd2;
      if (fmt == 3'd5 && (s < -(1 << 20) || s > (1 << 20) - 2)) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [31:0] ref_enc();
      logic [31:0] u, base;
      u    = i_imm;
      base = (32'(i_rd) << 7) | 32'(i_opcode);
      case (i_fmt)
         3'd0: return (32'(i_funct7) << 25) | (32'(i_rs2) << 20) | (32'(i_rs1) << 15) |
                      (32'(i_funct3) << 12) | base;
         3'd1: return ((u & 32'hfff) << 20) | (32'(i_rs1) << 15) | (32'(i_funct3) << 12) | base;
         3'd2: return (((u >> 5) & 32'h7f) << 25) | (32'(i_rs2) << 20) | (32'(i_rs1) << 15) |
                      (32'(i_funct3) << 12) | ((u & 32'h1f) << 7) | 32'(i_opcode);
         3'd3: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3f) << 25) |
                      (32'(i_rs2) << 20) | (32'(i_rs1) << 15) | (32'(i_funct3) << 12) |
                      (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 32'h1) << 7) | 32'(i_opcode);
         3'd4: return (u & 32'hfffff000) | base;
         3'd5: return (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3ff) << 21) |
                      (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hff) << 12) | base;
         default: return 32'd0;
      endcase
   endfunction

   // Advance one clock; the model consumes the inputs present before the edge
   task automatic tick();
      bit          acc, cons, rst_cur;
      logic [1:0]  code;
      logic [31:0] enc;
      rst_cur = sel ? rst_b : rst_a;
      acc  = i_valid && m_ready();
      cons = m_held && o_ready;
      code = ref_code(i_fmt, i_imm);
      enc  = ref_enc();
      @(posedge clk);
      if (rst_cur) begin
         model_reset();
      end else begin
         m_err = acc && (code != 2'd0);
         if (m_err) m_code = code;
         if (cons) begin
            m_addr  = (m_addr + 1) % m_cap;
            m_count = m_count + 1;
            if (m_count == m_cap) begin
               m_full = 1'b1; m_held = 1'b0;
            end else if (acc && code == 2'd0) begin
               m_held = 1'b1; m_insn = enc;
            end else begin
               m_held = 1'b0;
            end
         end else if (acc && code == 2'd0) begin
            m_held = 1'b1; m_insn = enc;
         end
      end
      #1;
   endtask

   task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm);
      i_fmt = f; i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
      i_funct3 = f3; i_funct7 = f7; i_imm = imm; i_valid = 1'b1;
   endtask

   function automatic logic [31:0] rand_imm();
      int k;
      k = $urandom_range(0, 19);
      case (k)
         0:  return 32'd2047;
         1:  return 32'd2048;
         2:  return 32'hfffff800;
         3:  return 32'hfffff7ff;
         4:  return 32'd4094;
         5:  return 32'd4096;
         6:  return 32'hfffff000;
         7:  return 32'hffffeffe;
         8:  return 32'h000ffffe;
         9:  return 32'h00100000;
         10: return 32'hfff00000;
         11: return 32'hffeffffe;
         12: return 32'h12345000;
         13: return 32'h12345800;
         14, 15, 16: return 32'($urandom_range(0, 200)) - 32'd100;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      rst_a = 1'b1;
      tick(); tick();
      rst_a = 1'b0;
      #1;
      checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_o_valid); end
      checks++; if (a_o_insn !== 32'd0) begin errors++; $display("FAIL reset_insn: got %h want 0", a_o_insn); end
      checks++; if (a_o_err !== 1'b0 || a_o_err_code !== 2'd0) begin errors++; $display("FAIL reset_err: got %b/%0d want 0/0", a_o_err, a_o_err_code); end
      checks++; if (a_o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", a_o_full); end
      checks++; if (a_o_addr !== 10'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", a_o_addr); end
      checks++; if (a_i_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", a_i_ready); end
   endtask

   task automatic test_single();
      o_ready = 1'b1;
      set_req(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd13);
      tick();
      i_valid = 1'b0;
      checks++; if (a_o_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", a_o_valid); end
      checks++; if (a_o_insn !== 32'h00d00013) begin errors++; $display("FAIL single_insn: got %h want 00d00013", a_o_insn); end
      checks++; if (a_o_addr !== 10'd0) begin errors++; $display("FAIL single_addr: got %0d want 0", a_o_addr); end
      tick();
      checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", a_o_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [3];
      exp_w = '{32'h00000563, 32'h004000ef, 32'h00208167};
      o_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: set_req(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10);
            1: set_req(3'd5, 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4);
            default: set_req(3'd1, 7'h67, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2);
         endcase
         #1;
         checks++; if (a_i_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, a_i_ready); end
         tick();
         checks++; if (a_o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, a_o_valid); end
         checks++; if (a_o_insn !== exp_w[k]) begin errors++; $display("FAIL b2b_insn[%0d]: got %h want %h", k, a_o_insn, exp_w[k]); end
         checks++; if (a_o_addr !== 10'(k + 1)) begin errors++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", k, a_o_addr, k + 1); end
      end
      i_valid = 1'b0;
      tick();
      checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", a_o_valid); end
   endtask

   task automatic test_errors();
      logic [1:0] exp_c [3];
      exp_c = '{2'd1, 2'd2, 2'd3};
      o_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: set_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
            1: set_req(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048);
            default: set_req(3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
         endcase
         tick();
         i_valid = 1'b0;
         checks++; if (a_o_err !== 1'b1) begin errors++; $display("FAIL err_pulse[%0d]: got %b want 1", k, a_o_err); end
         checks++; if (a_o_err_code !== exp_c[k]) begin errors++; $display("FAIL err_code[%0d]: got %0d want %0d", k, a_o_err_code, exp_c[k]); end
         checks++; if (a_o_valid !== 1'b0 || a_o_addr !== 10'd4) begin errors++; $display("FAIL err_noword[%0d]: got valid=%b addr=%0d want 0/4", k, a_o_valid, a_o_addr); end
         tick();
         checks++; if (a_o_err !== 1'b0) begin errors++; $display("FAIL err_oneshot[%0d]: got %b want 0", k, a_o_err); end
      end
      checks++; if (a_o_err_code !== 2'd3) begin errors++; $display("FAIL err_code_hold: got %0d want 3", a_o_err_code); end
      set_req(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      tick();
      i_valid = 1'b0;
      checks++; if (a_o_valid !== 1'b1 || a_o_addr !== 10'd4 || a_o_insn !== 32'h00500193) begin
         errors++; $display("FAIL err_next_word: got valid=%b addr=%0d insn=%h want 1/4/00500193", a_o_valid, a_o_addr, a_o_insn); end
      tick();
   endtask

   task automatic test_backpressure();
      o_ready = 1'b0;
      set_req(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hfffffffc);
      tick();
      set_req(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hdead0000);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (a_i_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", k, a_i_ready); end
         tick();
         checks++; if (a_o_valid !== 1'b1 || a_o_insn !== 32'hfe512e23 || a_o_addr !== 10'd5) begin
            errors++; $display("FAIL bp_stable[%0d]: got valid=%b insn=%h addr=%0d want 1/fe512e23/5", k, a_o_valid, a_o_insn, a_o_addr); end
      end
      o_ready = 1'b1;
      #1;
      checks++; if (a_i_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", a_i_ready); end
      tick();
      i_valid = 1'b0;
      checks++; if (a_o_valid !== 1'b1 || a_o_insn !== 32'hdead03b7 || a_o_addr !== 10'd6) begin
         errors++; $display("FAIL bp_next: got valid=%b insn=%h addr=%0d want 1/dead03b7/6", a_o_valid, a_o_insn, a_o_addr); end
      tick();
   endtask

   task automatic test_stall_reset();
      stall = 1'b1; o_ready = 1'b1;
      set_req(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
      #1;
      checks++; if (a_i_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", a_i_ready); end
      tick();
      checks++; if (a_o_valid !== 1'b0) begin errors++; $display("FAIL stall_noaccept: got %b want 0", a_o_valid); end
      stall = 1'b0; o_ready = 1'b0;
      tick();
      stall = 1'b1; o_ready = 1'b1; i_valid = 1'b0;
      tick();
      checks++; if (a_o_valid !== 1'b0 || a_o_addr !== 10'd8) begin errors++; $display("FAIL stall_drain: got valid=%b addr=%0d want 0/8", a_o_valid, a_o_addr); end
      stall = 1'b0; o_ready = 1'b0;
      set_req(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
      tick();
      checks++; if (a_o_valid !== 1'b1 || a_o_addr !== 10'd8) begin errors++; $display("FAIL hold_before_rst: got valid=%b addr=%0d want 1/8", a_o_valid, a_o_addr); end
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0; i_valid = 1'b0;
      checks++; if (a_o_valid !== 1'b0 || a_o_addr !== 10'd0) begin errors++; $display("FAIL rst_in_hold: got valid=%b addr=%0d want 0/0", a_o_valid, a_o_addr); end
   endtask

   task automatic test_random();
      rst_a = 1'b1; stall = 1'b0; i_valid = 1'b0;
      tick();
      rst_a = 1'b0;
      for (int n = 0; n < 400; n++) begin
         stall   = ($urandom_range(0, 3) == 0);
         o_ready = ($urandom_range(0, 2) != 0);
         set_req(($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5)),
                 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                 7'($urandom), rand_imm());
         i_valid = ($urandom_range(0, 3) != 0);
         #1;
         checks++; if (a_i_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, a_i_ready, m_ready()); end
         tick();
         checks++; if (a_o_valid !== m_held) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, a_o_valid, m_held); end
         checks++; if (a_o_err !== m_err || a_o_err_code !== m_code) begin
            errors++; $display("FAIL rnd_err[%0d]: got %b/%0d want %b/%0d", n, a_o_err, a_o_err_code, m_err, m_code); end
         checks++; if (a_o_addr !== 10'(m_addr)) begin errors++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", n, a_o_addr, m_addr); end
         if (m_held) begin
            checks++; if (a_o_insn !== m_insn) begin errors++; $display("FAIL rnd_insn[%0d]: got %h want %h", n, a_o_insn, m_insn); end
         end
      end
      stall = 1'b0; i_valid = 1'b0;
   endtask

   task automatic test_full();
      rst_a = 1'b1; sel = 1'b1; m_cap = 4; stall = 1'b0; i_valid = 1'b0;
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      checks++; if (b_o_full !== 1'b0 || b_o_addr !== 2'd0) begin errors++; $display("FAIL full_reset: got full=%b addr=%0d want 0/0", b_o_full, b_o_addr); end
      o_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
         #1;
         checks++; if (b_i_ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready[%0d]: got %b want 1", k, b_i_ready); end
         tick();
         checks++; if (b_o_valid !== 1'b1 || b_o_addr !== 2'(k) || b_o_insn !== m_insn) begin
            errors++; $display("FAIL full_fill[%0d]: got valid=%b addr=%0d insn=%h want 1/%0d/%h", k, b_o_valid, b_o_addr, b_o_insn, k, m_insn); end
      end
      i_valid = 1'b0;
      tick();
      checks++; if (b_o_full !== 1'b1 || b_o_valid !== 1'b0 || b_o_addr !== 2'd0) begin
         errors++; $display("FAIL full_reached: got full=%b valid=%b addr=%0d want 1/0/0", b_o_full, b_o_valid, b_o_addr); end
      for (int k = 0; k < 3; k++) begin
         set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
         #1;
         checks++; if (b_i_ready !== 1'b0) begin errors++; $display("FAIL full_ready[%0d]: got %b want 0", k, b_i_ready); end
         tick();
         checks++; if (b_o_valid !== 1'b0 || b_o_full !== m_full) begin errors++; $display("FAIL full_terminal[%0d]: got valid=%b full=%b want 0/1", k, b_o_valid, b_o_full); end
      end
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0; i_valid = 1'b0;
      #1;
      checks++; if (b_o_full !== 1'b0 || b_i_ready !== 1'b1) begin errors++; $display("FAIL full_cleared: got full=%b ready=%b want 0/1", b_o_full, b_i_ready); end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; stall = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
      i_fmt = '0; i_opcode = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0;
      i_funct3 = '0; i_funct7 = '0; i_imm = '0;
      model_reset();
      test_reset();
      test_single();
      test_back_to_back();
      test_errors();
      test_backpressure();
      test_stall_reset();
      test_random();
      test_full();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/insn_encoder.md
Name: insn_encoder

Overview:
- Inverse of the immediate generator: takes decoded instruction fields plus a full 32-bit immediate and packs them into a 32-bit RV32I instruction word.
- Emits one word per handshake, with an auto-incrementing word address, into the instruction-memory loader used by benches and the boot path.
- Checks immediate range and alignment per format. Rejects illegal requests with an error pulse instead of emitting a word.

Parameters:
- ADDR_W, 10, word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, word address loaded into the counter at reset.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- stall  input  1  global pipeline stall; blocks acceptance while high
- i_valid  input  1  request valid
- i_ready  output  1  request accepted when i_valid && i_ready
- i_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
- i_opcode  input  7  opcode field
- i_rd  input  5  destination register
- i_rs1  input  5  source register 1
- i_rs2  input  5  source register 2
- i_funct3  input  3  funct3
- i_funct7  input  7  funct7 (R only)
- i_imm  input  32  byte-offset / value immediate (U: full upper value)
- o_valid  output  1  o_insn/o_addr valid
- o_ready  input  1  downstream accepts word when o_valid && o_ready
- o_insn  output  32  encoded instruction
- o_addr  output  ADDR_W  word address of o_insn
- o_err  output  1  one-cycle pulse for a rejected request
- o_err_code  output  2  1=misaligned, 2=out of range, 3=illegal fmt; held until next error
- o_full  output  1  all 2^ADDR_W words emitted

Behaviour:

Reset values:
- o_valid=0, o_insn=0, o_err=0, o_err_code=0, o_full=0.
- Address counter=BASE_ADDR; emitted count=0; state EMPTY.
- Reset mid-transfer drops any held word; no partial output.

States:
- EMPTY: no word held.
- HOLD: word held, waiting for o_ready.
- FULL: capacity reached; terminal until rst.

Acceptance and transitions:
- i_ready = !stall && state!=FULL && (state==EMPTY || o_ready).
- On acceptance, encode and check combinationally; result registered next edge (latency 1 cycle).
- Legal request: o_valid=1, o_insn=encoding, o_addr=counter; go to HOLD.
- Illegal request: o_err=1 for one cycle, o_err_code set, no word emitted, counter unchanged. State becomes EMPTY, unless a held word was simultaneously consumed.
- Word consumed (o_valid && o_ready): counter += 1 mod 2^ADDR_W; count += 1.
  - If count reaches 2^ADDR_W: go to FULL, o_full=1, o_valid=0.
  - Else if a new legal request is accepted the same cycle: stay in HOLD with the new word (back-to-back, one word/cycle).
  - Else: go to EMPTY.
- While in HOLD with o_ready=0: o_insn/o_addr stable, i_ready=0, regardless of stall.
- stall does not affect the output side; a held word may drain during stall.

Encoding (imm = i_imm):
- R: {f7,rs2,rs1,f3,rd,op}
- I: {imm[11:0],rs1,f3,rd,op}
- S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}
- B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
- U: {imm[31:12],rd,op}
- J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}

Checks, in priority order:
- Illegal fmt: code 3.
- B or J with imm[0]=1, or U with imm[11:0]!=0: code 1.
- Signed range exceeded: code 2. Limits are I/S [-2048,2047], B [-4096,4094], J [-2^20, 2^20-2].
- R ignores i_imm entirely.

Test Plan:
1. Reset, then I fmt op=0x13 rd=0 rs1=0 f3=0 imm=13 → o_insn=0x00d00013, o_addr=0, o_valid one cycle after accept.
2. Back-to-back with o_ready=1:
   - B op=0x63 imm=10 → 0x00000563, addr 1.
   - J op=0x6f rd=1 imm=4 → 0x004000ef, addr 2.
   - I op=0x67 rd=2 rs1=1 imm=2 → 0x00208167, addr 3.
   - One word per cycle, no bubbles.
3. Error cases:
   - B imm=3 → o_err pulse, code 1.
   - I imm=2048 → code 2.
   - fmt=7 → code 3.
   - In all cases no o_valid and the counter is unchanged; the next legal word gets the next address.
4. Backpressure: hold o_ready=0 for 3 cycles with a word held → o_insn/o_addr stable, i_ready=0; release → word consumed, next request accepted the same cycle.
5. Stall/reset:
   - stall=1 with i_valid=1 → i_ready=0, no accept.
   - Assert rst while in HOLD → next cycle o_valid=0, addr back to BASE_ADDR.
6. ADDR_W=2: emit 4 words → o_full=1 after the 4th consume, i_ready=0, counter wrapped to 0; a further request is never accepted until rst.
